// File: rtl/duft_ap_chain_queued.sv
// Queued ap_ctrl_chain wrapper for the DUFT core: command FIFO -> issue engine -> result FIFO.
// Optional DUFT_CHAIN_STATS_EN adds saturating op / stall counters.
module duft_ap_chain_queued #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int RES_DEPTH  = 4,
  parameter int RST_CYCLES = 2
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wr_data,
  input  logic [1:0]    rd_wr,
  input  logic          ap_start,
  output logic          ap_ready,
  input  logic          ap_ce,
  output logic          ap_done,
  input  logic          ap_continue,
  output logic [DW-1:0] ap_return,
  output logic          ap_idle,
  output logic          core_reset,
  output logic [AW-1:0] core_rd_addr,
  output logic [AW-1:0] core_wr_addr,
  output logic [DW-1:0] core_wr_msg,
  input  logic [DW-1:0] core_rd_msg
`ifdef DUFT_CHAIN_STATS_EN
  ,
  output logic [31:0]   stat_ops,
  output logic [31:0]   stat_ce_stall,
  output logic [31:0]   stat_full_stall
`endif
);

  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int CCW = CPW + 1;
  localparam int RPW = $clog2(RES_DEPTH);
  localparam int RCW = RPW + 1;
  localparam int RSW = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RST
  } state_e;

  logic [AW-1:0]  c_addr_q [CMD_DEPTH];
  logic [DW-1:0]  c_data_q [CMD_DEPTH];
  logic [1:0]     c_op_q   [CMD_DEPTH];
  logic [CPW-1:0] c_wp_q, c_rp_q;
  logic [CCW-1:0] c_cnt_q, c_cnt_d;

  logic [DW-1:0]  r_mem_q [RES_DEPTH];
  logic [RPW-1:0] r_wp_q, r_rp_q;
  logic [RCW-1:0] r_cnt_q, r_cnt_d;

  state_e         state_q, state_d;
  logic [RSW-1:0] rcnt_q, rcnt_d;

  logic          c_full, c_empty, c_push, c_pop;
  logic          r_full, r_empty, r_push, r_pop;
  logic [DW-1:0] r_push_data;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_data;
  logic [1:0]    h_op;
  logic          h_rst, h_rd, h_wr;
  logic          eligible, issue, rst_done;

  assign c_full  = (c_cnt_q == CCW'(CMD_DEPTH));
  assign c_empty = (c_cnt_q == '0);
  assign r_full  = (r_cnt_q == RCW'(RES_DEPTH));
  assign r_empty = (r_cnt_q == '0);

  assign c_push = ap_start & ~c_full;
  assign r_pop  = ~r_empty & ap_continue;

  assign h_addr = c_addr_q[c_rp_q];
  assign h_data = c_data_q[c_rp_q];
  assign h_op   = c_op_q[c_rp_q];

  // bit1 (soft reset) outranks bit0 (read)
  always_comb begin
    h_rst = 1'b0;
    h_rd  = 1'b0;
    h_wr  = 1'b0;
    priority case (1'b1)
      h_op[1]: h_rst = 1'b1;
      h_op[0]: h_rd  = 1'b1;
      default: h_wr  = 1'b1;
    endcase
  end

  // IDLE also issues so an idle block reaches the core one cycle after accept
  assign eligible = (state_q != S_RST) & ~c_empty;
  assign issue    = eligible & ap_ce & ~r_full;
  assign rst_done = (state_q == S_RST)
                  & (rcnt_q == RSW'(RST_CYCLES - 1));

  assign c_pop       = issue;
  assign r_push      = (issue & ~h_rst) | rst_done;
  assign r_push_data = (issue & h_rd) ? core_rd_msg : '0;

  assign c_cnt_d = c_cnt_q + CCW'(c_push) - CCW'(c_pop);
  assign r_cnt_d = r_cnt_q + RCW'(r_push) - RCW'(r_pop);

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      S_IDLE, S_ISSUE: begin
        if (issue & h_rst) begin
          state_d = S_RST;
          rcnt_d  = '0;
        end else begin
          state_d = (c_cnt_d != '0) ? S_ISSUE : S_IDLE;
        end
      end
      S_RST: begin
        if (rst_done) begin
          state_d = (c_cnt_d != '0) ? S_ISSUE : S_IDLE;
        end else begin
          rcnt_d = rcnt_q + RSW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      rcnt_q  <= '0;
      c_wp_q  <= '0;
      c_rp_q  <= '0;
      c_cnt_q <= '0;
      r_wp_q  <= '0;
      r_rp_q  <= '0;
      r_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      c_cnt_q <= c_cnt_d;
      r_cnt_q <= r_cnt_d;
      if (c_push) c_wp_q <= c_wp_q + CPW'(1);
      if (c_pop)  c_rp_q <= c_rp_q + CPW'(1);
      if (r_push) r_wp_q <= r_wp_q + RPW'(1);
      if (r_pop)  r_rp_q <= r_rp_q + RPW'(1);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (c_push) begin
      c_addr_q[c_wp_q] <= addr;
      c_data_q[c_wp_q] <= wr_data;
      c_op_q[c_wp_q]   <= rd_wr;
    end
    if (r_push) r_mem_q[r_wp_q] <= r_push_data;
  end

  assign ap_ready     = ~c_full;
  assign ap_done      = ~r_empty;
  assign ap_return    = r_empty ? '0 : r_mem_q[r_rp_q];
  assign ap_idle      = c_empty & r_empty & (state_q == S_IDLE);
  assign core_reset   = (state_q == S_RST);
  assign core_rd_addr = (issue & h_rd) ? h_addr : '1;
  assign core_wr_addr = (issue & h_wr) ? h_addr : '1;
  assign core_wr_msg  = (issue & h_wr) ? h_data : '0;

`ifdef DUFT_CHAIN_STATS_EN
  logic [31:0] ops_q, ce_q, full_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ops_q  <= '0;
      ce_q   <= '0;
      full_q <= '0;
    end else if (issue & h_rst) begin
      ops_q  <= '0;
      ce_q   <= '0;
      full_q <= '0;
    end else begin
      if (issue && ops_q != '1)
        ops_q <= ops_q + 32'd1;
      if (eligible && !ap_ce && ce_q != '1)
        ce_q <= ce_q + 32'd1;
      if (eligible && ap_ce && r_full && full_q != '1)
        full_q <= full_q + 32'd1;
    end
  end

  assign stat_ops        = ops_q;
  assign stat_ce_stall   = ce_q;
  assign stat_full_stall = full_q;
`endif

endmodule

// File: tb/tb_duft_ap_chain_queued.sv
// Bench for duft_ap_chain_queued: directed latency/reset cases plus
// randomized traffic scored against a queue-based command/result model.
module tb_duft_ap_chain_queued;

  localparam int RSTC = 2;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [1:0]  rd_wr;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_ce;
  logic        ap_done;
  logic        ap_continue;
  logic [31:0] ap_return;
  logic        ap_idle;
  logic        core_reset;
  logic [31:0] core_rd_addr;
  logic [31:0] core_wr_addr;
  logic [31:0] core_wr_msg;
  logic [31:0] core_rd_msg;
`ifdef DUFT_CHAIN_STATS_EN
  logic [31:0] stat_ops, stat_ce_stall, stat_full_stall;
`endif

  duft_ap_chain_queued #(
    .DW(32), .AW(32), .CMD_DEPTH(4),
    .RES_DEPTH(4), .RST_CYCLES(RSTC)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .addr(addr),
    .wr_data(wr_data),
    .rd_wr(rd_wr),
    .ap_start(ap_start),
    .ap_ready(ap_ready),
    .ap_ce(ap_ce),
    .ap_done(ap_done),
    .ap_continue(ap_continue),
    .ap_return(ap_return),
    .ap_idle(ap_idle),
    .core_reset(core_reset),
    .core_rd_addr(core_rd_addr),
    .core_wr_addr(core_wr_addr),
    .core_wr_msg(core_wr_msg),
    .core_rd_msg(core_rd_msg)
`ifdef DUFT_CHAIN_STATS_EN
    ,
    .stat_ops(stat_ops),
    .stat_ce_stall(stat_ce_stall),
    .stat_full_stall(stat_full_stall)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
  } acc_t;

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] cmem [256];
  logic [31:0] emem [256];
  acc_t        eq[$];
  logic [31:0] rq[$];

  assign core_rd_msg = cmem[core_rd_addr[7:0]];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: core access order, reset pulse width, result order, accepts.
  initial begin
    bit   prev_rst;
    int   rst_len;
    acc_t e, n;
    prev_rst = 0;
    rst_len  = 0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        prev_rst = 0;
        rst_len  = 0;
      end else begin
        chk("one_access",
            (core_rd_addr != '1) && (core_wr_addr != '1), 0);
        chk("rst_noaddr", core_reset &&
            ((core_rd_addr != '1) || (core_wr_addr != '1)), 0);
        if (core_rd_addr != '1) begin
          if (eq.size() == 0) chk("rd_unexp", 1, 0);
          else begin
            e = eq.pop_front();
            chk("rd_kind", e.kind, 1);
            chk("rd_addr", core_rd_addr, e.a);
          end
        end
        if (core_wr_addr != '1) begin
          if (eq.size() == 0) chk("wr_unexp", 1, 0);
          else begin
            e = eq.pop_front();
            chk("wr_kind", e.kind, 0);
            chk("wr_addr", core_wr_addr, e.a);
            chk("wr_data", core_wr_msg, e.d);
          end
          cmem[core_wr_addr[7:0]] = core_wr_msg;
        end
        if (core_reset && !prev_rst) begin
          if (eq.size() == 0) chk("srst_unexp", 1, 0);
          else begin
            e = eq.pop_front();
            chk("srst_kind", e.kind, 2);
          end
        end
        if (core_reset) rst_len++;
        else if (rst_len != 0) begin
          chk("srst_len", rst_len, RSTC);
          rst_len = 0;
        end
        prev_rst = core_reset;
        if (ap_done && ap_continue) begin
          if (rq.size() == 0) chk("res_unexp", 1, 0);
          else chk("ap_return", ap_return, rq.pop_front());
        end
        if (ap_start && ap_ready) begin
          n.a = addr;
          n.d = wr_data;
          if (rd_wr[1]) begin
            n.kind = 2;
            rq.push_back(32'h0);
          end else if (rd_wr[0]) begin
            n.kind = 1;
            rq.push_back(emem[addr[7:0]]);
          end else begin
            n.kind = 0;
            emem[addr[7:0]] = wr_data;
            rq.push_back(32'h0);
          end
          eq.push_back(n);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] d, input bit rnd);
    int n;
    bit acc;
    n   = 0;
    acc = 0;
    ap_start = 1;
    rd_wr    = op;
    addr     = a;
    wr_data  = d;
    while (!acc && n < 200) begin
      if (rnd) begin
        ap_ce       = ($urandom_range(3) != 0);
        ap_continue = ($urandom_range(9) < 7);
      end
      @(negedge ap_clk);
      acc = ap_ready;
      n++;
      @(posedge ap_clk);
      #1;
    end
    ap_start = 0;
    chk("send_timeout", acc, 1);
  endtask

  task automatic wait_idle();
    int n;
    ap_ce       = 1;
    ap_continue = 1;
    n = 0;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!ap_idle && n < 300);
    chk("idle_timeout", ap_idle, 1);
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    logic [31:0] d, s0;
    for (int i = 0; i < 256; i++) begin
      cmem[i] = '0;
      emem[i] = '0;
    end
    ap_rst_n    = 0;
    ap_start    = 0;
    addr        = '0;
    wr_data     = '0;
    rd_wr       = 2'b00;
    ap_ce       = 1;
    ap_continue = 1;
    s0          = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_ready", ap_ready, 1);
    chk("rst_done", ap_done, 0);
    chk("rst_idle", ap_idle, 1);
    chk("rst_return", ap_return, 0);
    chk("rst_core_reset", core_reset, 0);
    chk("rst_rd_addr", core_rd_addr, 32'hFFFF_FFFF);
    chk("rst_wr_addr", core_wr_addr, 32'hFFFF_FFFF);
    chk("rst_wr_msg", core_wr_msg, 0);
    ap_rst_n = 1;
    @(posedge ap_clk);
    #1;

    // write then read back-to-back, latency N+1 issue / N+2 done
    ap_start = 1; rd_wr = 2'b00; addr = 32'h10; wr_data = 32'hA5A5_A5A5;
    chk("t1_ready", ap_ready, 1);
    @(posedge ap_clk); #1;
    rd_wr = 2'b01; wr_data = 32'h0;
    chk("t1_wr_issue", core_wr_addr, 32'h10);
    chk("t1_wr_msg", core_wr_msg, 32'hA5A5_A5A5);
    chk("t1_done_n1", ap_done, 0);
    @(posedge ap_clk); #1;
    ap_start = 0;
    chk("t1_done_n2", ap_done, 1);
    chk("t1_res0", ap_return, 0);
    chk("t1_rd_issue", core_rd_addr, 32'h10);
    @(posedge ap_clk); #1;
    chk("t1_done_n3", ap_done, 1);
    chk("t1_res1", ap_return, 32'hA5A5_A5A5);
    repeat (2) @(posedge ap_clk);
    #1;
    chk("t1_idle", ap_idle, 1);

    // fill both FIFOs with ap_continue low
    wait_idle();
`ifdef DUFT_CHAIN_STATS_EN
    s0 = stat_full_stall;
`endif
    ap_continue = 0;
    for (int i = 0; i < 8; i++)
      send((i % 2) ? 2'b01 : 2'b00, 32'h40 + i, $urandom, 0);
    ap_start = 1; rd_wr = 2'b01; addr = 32'h40; wr_data = 0;
    @(negedge ap_clk);
    chk("t2_full_ready", ap_ready, 0);
    chk("t2_done", ap_done, 1);
    chk("t2_idle", ap_idle, 0);
`ifdef DUFT_CHAIN_STATS_EN
    chk("t2_full_stall", stat_full_stall != s0, 1);
`endif
    @(posedge ap_clk); #1;
    ap_continue = 1;
    send(2'b01, 32'h40, 0, 0);
    wait_idle();

    // ap_ce held low for three cycles
`ifdef DUFT_CHAIN_STATS_EN
    s0 = stat_ce_stall;
`endif
    ap_ce = 0;
    send(2'b01, 32'h10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      chk("t3_ce_hold", core_rd_addr, 32'hFFFF_FFFF);
      @(posedge ap_clk); #1;
    end
    ap_ce = 1;
    @(negedge ap_clk);
    chk("t3_ce_issue", core_rd_addr, 32'h10);
`ifdef DUFT_CHAIN_STATS_EN
    chk("t3_ce_stat", stat_ce_stall - s0, 3);
`endif
    wait_idle();

    // soft reset pulse and its result
    ap_start = 1; rd_wr = 2'b11; addr = 32'h22; wr_data = 0;
    @(posedge ap_clk); #1;
    ap_start = 0;
    chk("t4_n1_reset", core_reset, 0);
    for (int i = 0; i < RSTC; i++) begin
      @(posedge ap_clk); #1;
      chk("t4_reset_hi", core_reset, 1);
      chk("t4_done_lo", ap_done, 0);
    end
    @(posedge ap_clk); #1;
    chk("t4_reset_end", core_reset, 0);
    chk("t4_done", ap_done, 1);
    chk("t4_return", ap_return, 0);
    wait_idle();
`ifdef DUFT_CHAIN_STATS_EN
    chk("t4_ops_clr", stat_ops, 0);
`endif

    // asynchronous reset with commands queued
    ap_ce = 0;
    for (int i = 0; i < 3; i++) send(2'b01, 32'h50 + i, 0, 0);
    chk("t5_pre_idle", ap_idle, 0);
    ap_rst_n = 0;
    #1;
    chk("t5_ready", ap_ready, 1);
    chk("t5_done", ap_done, 0);
    chk("t5_idle", ap_idle, 1);
    chk("t5_rd_addr", core_rd_addr, 32'hFFFF_FFFF);
    eq.delete();
    rq.delete();
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1;
    ap_ce    = 1;
    repeat (10) @(posedge ap_clk);
    #1;
    chk("t5_still_idle", ap_idle, 1);

    // pointer wrap: write/read pairs
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      send(2'b00, i, d, 0);
      send(2'b01, i, 0, 0);
    end
    wait_idle();
`ifdef DUFT_CHAIN_STATS_EN
    chk("t6_ops", stat_ops, 40);
`endif

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(19);
      repeat ($urandom_range(2)) @(posedge ap_clk);
      #1;
      if (r < 2) send({1'b1, 1'($urandom)}, $urandom_range(15), 0, 1);
      else if (r < 11) send(2'b00, $urandom_range(15), $urandom, 1);
      else send(2'b01, $urandom_range(15), 0, 1);
    end
    wait_idle();
    chk("rand_res_left", rq.size(), 0);
    chk("rand_acc_left", eq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
